// File: rtl/text_tty.sv
// Character terminal: prints into text video memory and tracks the cursor.
// Define TEXT_TTY_SCROLL_EN to scroll at the bottom row; otherwise the cursor wraps to (0,0).
module text_tty #(
    parameter int COLS = 80,
    parameter int ROWS = 25
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [7:0]  char_data,
    input  logic [7:0]  char_attr,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        busy,
    output logic [7:0]  cursor_x,
    output logic [7:0]  cursor_y,
    output logic [12:0] text_address,
    output logic [7:0]  text_wdata,
    output logic        text_we,
    input  logic [7:0]  text_rdata
);

    localparam logic [7:0]  L_XMAX = 8'(COLS - 1);
    localparam logic [7:0]  L_YMAX = 8'(ROWS - 1);
    localparam logic [12:0] L_LAST = 13'(2 * COLS * ROWS - 1);
`ifdef TEXT_TTY_SCROLL_EN
    localparam logic [12:0] L_ROWB = 13'(2 * COLS);
    localparam logic [12:0] L_LROW = 13'(2 * COLS * (ROWS - 1));
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_WCHAR, S_WATTR, S_ADV, S_CLR
`ifdef TEXT_TTY_SCROLL_EN
        , S_SCR_RD, S_SCR_WR, S_SCR_CLR
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_char;
    logic [7:0]  r_attr;
    logic [12:0] r_addr;
    logic [12:0] w_cell;
    logic [12:0] w_caddr;
    logic        w_last;
    logic [7:0]  w_nx;
    logic [7:0]  w_ny;
    logic        w_nl;
    logic [8:0]  w_tab;
    logic [7:0]  w_fill;
`ifdef TEXT_TTY_SCROLL_EN
    logic        w_scr;
`else
    logic        w_unused;
    assign w_unused = ^text_rdata;
`endif

    assign cursor_x = r_x;
    assign cursor_y = r_y;
    assign w_cell   = 13'(r_x) + 13'(COLS) * 13'(r_y);
    assign w_caddr  = w_cell << 1;
    assign w_last   = (r_addr == L_LAST);
    assign w_fill   = r_addr[0] ? r_attr : 8'h20;

    // State register; reset aborts any scroll or clear in flight
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Cursor movement for the character held in r_char
    always_comb begin
        w_nx  = r_x;
        w_ny  = r_y;
        w_nl  = 1'b0;
        w_tab = ({1'b0, r_x} & 9'h1F8) + 9'd8;
`ifdef TEXT_TTY_SCROLL_EN
        w_scr = 1'b0;
`endif
        if (r_char >= 8'h20) begin
            if (r_x == L_XMAX) w_nl = 1'b1;
            else               w_nx = r_x + 8'd1;
        end else if (r_char == 8'h0D) begin
            w_nx = 8'd0;
        end else if (r_char == 8'h0A) begin
            w_nl = 1'b1;
        end else if (r_char == 8'h08) begin
            if (r_x != 8'd0) w_nx = r_x - 8'd1;
        end else if (r_char == 8'h09) begin
            w_nx = (w_tab > {1'b0, L_XMAX}) ? L_XMAX : w_tab[7:0];
        end
        if (w_nl) begin
            w_nx = 8'd0;
            if (r_y == L_YMAX) begin
`ifdef TEXT_TTY_SCROLL_EN
                w_scr = 1'b1;
`else
                w_ny = 8'd0;
`endif
            end else begin
                w_ny = r_y + 8'd1;
            end
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (char_valid) begin
                    if (char_data == 8'h0C)      w_next = S_CLR;
                    else if (char_data >= 8'h20) w_next = S_WCHAR;
                    else                         w_next = S_ADV;
                end
            end
            S_WCHAR: w_next = S_WATTR;
            S_WATTR: w_next = S_ADV;
`ifdef TEXT_TTY_SCROLL_EN
            S_ADV:     w_next = w_scr ? S_SCR_RD : S_IDLE;
            S_SCR_RD:  w_next = S_SCR_WR;
            S_SCR_WR:  w_next = w_last ? S_SCR_CLR : S_SCR_RD;
            S_SCR_CLR: if (w_last) w_next = S_IDLE;
`else
            S_ADV:     w_next = S_IDLE;
`endif
            S_CLR:   if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory port and status outputs decoded from the current state
    always_comb begin
        char_ready   = 1'b0;
        busy         = 1'b0;
        text_address = 13'd0;
        text_wdata   = 8'd0;
        text_we      = 1'b0;
        case (r_state)
            S_IDLE: char_ready = 1'b1;
            S_WCHAR: begin
                text_we      = 1'b1;
                text_address = w_caddr;
                text_wdata   = r_char;
            end
            S_WATTR: begin
                text_we      = 1'b1;
                text_address = w_caddr + 13'd1;
                text_wdata   = r_attr;
            end
            S_CLR: begin
                busy         = 1'b1;
                text_we      = 1'b1;
                text_address = r_addr;
                text_wdata   = w_fill;
            end
`ifdef TEXT_TTY_SCROLL_EN
            S_SCR_RD: begin
                busy         = 1'b1;
                text_address = r_addr;
            end
            S_SCR_WR: begin
                busy         = 1'b1;
                text_we      = 1'b1;
                text_address = r_addr - L_ROWB;
                text_wdata   = text_rdata;
            end
            S_SCR_CLR: begin
                busy         = 1'b1;
                text_we      = 1'b1;
                text_address = r_addr;
                text_wdata   = w_fill;
            end
`endif
            default: ;
        endcase
    end

    // Cursor, latched character/attribute and block-operation address
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_x    <= 8'd0;
            r_y    <= 8'd0;
            r_char <= 8'd0;
            r_attr <= 8'd0;
            r_addr <= 13'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (char_valid) begin
                        r_char <= char_data;
                        r_attr <= char_attr;
                        r_addr <= 13'd0;
                    end
                end
                S_ADV: begin
                    r_x <= w_nx;
                    r_y <= w_ny;
`ifdef TEXT_TTY_SCROLL_EN
                    r_addr <= L_ROWB;
`endif
                end
                S_CLR: begin
                    r_addr <= r_addr + 13'd1;
                    if (w_last) begin
                        r_x <= 8'd0;
                        r_y <= 8'd0;
                    end
                end
`ifdef TEXT_TTY_SCROLL_EN
                S_SCR_WR: r_addr <= w_last ? L_LROW : r_addr + 13'd1;
                S_SCR_CLR: begin
                    r_addr <= r_addr + 13'd1;
                    if (w_last) begin
                        r_x <= 8'd0;
                        r_y <= L_YMAX;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/text_tty.md
TEXT_TTY -- requirements
Module: text_tty

Interface
REQ-001 SHALL have parameter COLS, default 80: text columns.
REQ-002 SHALL have parameter ROWS, default 25: text rows.
REQ-003 SHALL have port CLOCK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port char_data, input, 8 bits: character code or control code to emit.
REQ-006 SHALL have port char_attr, input, 8 bits: attribute byte; [3:0] foreground index, [7:4] background index.
REQ-007 SHALL have port char_valid, input, 1 bit: char_data and char_attr are valid.
REQ-008 SHALL have port char_ready, output, 1 bit: the block accepts a character this cycle.
REQ-009 SHALL have port busy, output, 1 bit: a scroll or clear-screen operation is in progress.
REQ-010 SHALL have port cursor_x, output, 8 bits: current column, 0..COLS-1.
REQ-011 SHALL have port cursor_y, output, 8 bits: current row, 0..ROWS-1.
REQ-012 SHALL have port text_address, output, 13 bits: byte address into text video memory.
REQ-013 SHALL have port text_wdata, output, 8 bits: write data.
REQ-014 SHALL have port text_we, output, 1 bit: write strobe, one byte per cycle.
REQ-015 SHALL have port text_rdata, input, 8 bits: read data, valid one cycle after text_address is driven.

Function
REQ-016 SHALL use the memory layout char at 2*(x+COLS*y) and attribute at char address+1; no byte above 2*COLS*ROWS-1 (0xF9F) is ever written, so the palette at 0xFA0 and font memory stay untouched.
REQ-017 SHALL accept a character on any edge with char_valid&&char_ready; char_ready is high only in state IDLE.
REQ-018 SHALL handle a printable code (0x20..0xFF) in three stages: WCHAR, next cycle (we=1, addr=2*(x+COLS*y), data=char); WATTR, next cycle (we=1, addr+1, data=attr latched at accept); ADV, next cycle (cursor advance, no write).
REQ-019 SHALL return char_ready high 4 cycles after acceptance for a printable code when no scroll is needed.
REQ-020 SHALL, on advance, do x+1; at x=COLS-1 set x=0 and y+1; when y would reach ROWS, start a scroll (REQ-023).
REQ-021 SHALL handle control codes in a single ADV cycle with no memory write: 0x0D sets x=0; 0x0A sets x=0 and y+1 (scroll at bottom); 0x08 sets x-1 only when x>0 and leaves x=0 unchanged; 0x09 moves x to the next multiple of 8, clamped to COLS-1.
REQ-022 SHALL treat any other code 0x00..0x1F except 0x0C as ignored, and 0x0C as clear screen (REQ-024).
REQ-023 SHALL scroll (states SCR_RD/SCR_WR, busy=1) as follows: for A = 2*COLS .. 2*COLS*ROWS-1 ascending, SCR_RD drives addr=A with we=0, then SCR_WR drives addr=A-2*COLS, we=1, data=text_rdata (2 cycles per byte); state SCR_CLR then writes the last row at 1 byte per cycle (char 0x20, attr latched); afterwards x=0, y=ROWS-1, return to IDLE.
REQ-024 SHALL clear the screen (state CLR, busy=1) by writing all 2*COLS*ROWS bytes at 1 per cycle (even bytes 0x20, odd bytes latched attr), then set x=0, y=0 and return to IDLE.
REQ-025 SHALL keep text_we low in IDLE, ADV and SCR_RD.
REQ-026 SHALL keep address arithmetic at 13 bits; COLS*ROWS*2 SHALL be at most 4000.

Reset
REQ-027 SHALL, while RESET=1, immediately force state=IDLE, cursor_x=0, cursor_y=0, text_address=0, text_wdata=0, text_we=0, busy=0; char_ready=1 after release.
REQ-028 SHALL abort an in-progress scroll or clear on RESET without completing it; memory content is then undefined and no further write occurs.

Configuration
REQ-029 SHALL, with macro TEXT_TTY_SCROLL_EN defined, scroll as in REQ-023 when the cursor passes row ROWS-1.
REQ-030 SHALL, without TEXT_TTY_SCROLL_EN, omit the scroll states, wrap the cursor to y=0 with x=0 instead of scrolling, and keep busy asserted only during clear.

Verification
REQ-031 SHALL be verified by: reset, send 'A' (0x41) attr 0x17 at (0,0) -> write 0x41@0x000, then 0x17@0x001 on consecutive cycles; cursor (1,0); ready back after 4 cycles.
REQ-032 SHALL be verified by: cursor (79,3), send 0x42 -> write @0x27E/0x27F; cursor (0,4).
REQ-033 SHALL be verified by: cursor (5,2), send 0x08, 0x0D, then 0x08 -> cursor (4,2), (0,2), (0,2); no text_we pulses.
REQ-034 SHALL be verified by: with SCROLL_EN, memory row 1 holding 'Z', cursor (0,24), send 0x0A -> row 0 reads 'Z'; row 24 is all 0x20/attr; busy high for 2*3840+160 cycles; cursor (0,24).
REQ-035 SHALL be verified by: send 0x0C with attr 0x07 -> 4000 writes, 0x000..0xF9F only, 0xFA0 never addressed; cursor (0,0).
REQ-036 SHALL be verified by: assert RESET mid-clear at byte 1000 -> text_we=0 at once; cursor (0,0); ready=1 after release.
